data_mem_responder: RTL

Data memory responder for the RV32I pipeline. Serves the MEM stage's load/store requests on port A: byte-lane stores, synchronous reads returned right-aligned, and misalignment/range faults. Serves a loader/debug master on port B through a req/ack handshake. Sits between the MEM stage and the on-chip RAM array, behind a true dual-port storage sub-module.

---
 rtl/RV32I_definitions.sv | 38 +++
 rtl/dmem_bram.sv | 48 ++++
 rtl/data_mem_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/RV32I_definitions.sv
// RV32I_definitions
// Shared definitions for the RV32I pipeline.
//   MEM_*        : mem_op encodings (funct3 of loads/stores). Bits [1:0] give
//                  the size (00 byte, 01 half, 1x word); bit 2 marks unsigned loads.
//   dbg_state_t  : state of the data-memory port B (loader/debug) FSM.
//   lane_mask    : byte-lane enables for a store of a given size and offset.
//   misaligned   : alignment fault for a given size and offset.
package RV32I_definitions;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;

   typedef enum logic [1:0] {
      B_IDLE   = 2'd0,
      B_ACCESS = 2'd1,
      B_DONE   = 2'd2
   } dbg_state_t;

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   lane_mask = 4'b0001 << off;
         2'b01:   lane_mask = 4'b0011 << {off[1], 1'b0};
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = off[0];
         default: misaligned = (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/dmem_bram.sv
// dmem_bram
// True dual-port word array with per-port byte enables and registered,
// read-first outputs (a read and a write of the same word in one cycle return
// the old contents). INIT_FILE is accepted for interface compatibility.
// Ports (per port x = a/b):
//   clk_i        clock
//   x_en_i       read enable; x_rdata_o updates only when set
//   x_be_i[3:0]  byte-lane write enables
//   x_addr_i     word index
//   x_wdata_i    write data (lane i uses bits [8i+7:8i])
//   x_rdata_o    registered read data
module dmem_bram #(
   parameter int    DEPTH     = 1024,
   parameter int    AW        = 10,
   parameter string INIT_FILE = ""
) (
   input  logic          clk_i,
   input  logic          a_en_i,
   input  logic [3:0]    a_be_i,
   input  logic [AW-1:0] a_addr_i,
   input  logic [31:0]   a_wdata_i,
   output logic [31:0]   a_rdata_o,
   input  logic          b_en_i,
   input  logic [3:0]    b_be_i,
   input  logic [AW-1:0] b_addr_i,
   input  logic [31:0]   b_wdata_i,
   output logic [31:0]   b_rdata_o
);

   logic [31:0] mem [DEPTH];
   logic [31:0] a_rdata_q;
   logic [31:0] b_rdata_q;

   // Both ports in one process so the array has a single driver. The top
   // never lets both ports write the same word in the same cycle.
   always_ff @(posedge clk_i) begin
      if (a_en_i) a_rdata_q <= mem[a_addr_i];
      if (b_en_i) b_rdata_q <= mem[b_addr_i];
      for (int i = 0; i < 4; i++) begin
         if (a_be_i[i]) mem[a_addr_i][i*8 +: 8] <= a_wdata_i[i*8 +: 8];
         if (b_be_i[i]) mem[b_addr_i][i*8 +: 8] <= b_wdata_i[i*8 +: 8];
      end
   end

   assign a_rdata_o = a_rdata_q;
   assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Data memory responder for the RV32I MEM stage (port A) and a loader/debug
// master (port B), in front of a dual-port RAM.
// Port A: mem_addr/mem_wr_data/mem_wr_en/mem_rd_en/mem_op request a byte,
//   half or word access; mem_rd_data returns the loaded value right-aligned
//   and zero-filled one cycle later; mem_fault pulses for one cycle on a
//   misaligned or out-of-range access; mem_rst clears mem_rd_data.
// Port B: dbg_req/dbg_we/dbg_addr/dbg_wdata request a word access.
//   Handshake: the master raises dbg_req with stable we/addr/wdata and holds
//   it until dbg_ack; dbg_ack is a one-cycle pulse and dbg_rdata is valid in
//   that cycle and held afterwards; the master drops dbg_req the cycle after.
// Clk / Reset_n: clock and synchronous active-low reset.
module data_mem_responder
   import RV32I_definitions::*;
#(
   parameter int    DEPTH_WORDS = 1024,
   parameter string INIT_FILE   = ""
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        mem_wr_en,
   input  logic        mem_rd_en,
   input  logic [2:0]  mem_op,
   input  logic        mem_rst,
   output logic [31:0] mem_rd_data,
   output logic        mem_fault,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_ack,
   output logic [31:0] dbg_rdata
);

   localparam int AW = $clog2(DEPTH_WORDS);

   // ---------------- port A decode ----------------
   logic        a_access, a_fault;
   logic [3:0]  a_be;
   logic [31:0] a_wdata, a_raw;
   logic [AW-1:0] a_idx;

   assign a_access = mem_wr_en | mem_rd_en;
   assign a_fault  = a_access & (misaligned(mem_op[1:0], mem_addr[1:0]) |
                     ({2'b00, mem_addr[31:2]} >= 32'(DEPTH_WORDS)));
   assign a_idx    = mem_addr[AW+1:2];
   // Writes are suppressed during reset and on any faulting access.
   assign a_be     = (mem_wr_en & ~a_fault & Reset_n) ?
                     lane_mask(mem_op[1:0], mem_addr[1:0]) : 4'b0000;
   // Replicate the low byte/half across the word so every lane sees its data.
   always_comb begin
      case (mem_op[1:0])
         2'b00:   a_wdata = {4{mem_wr_data[7:0]}};
         2'b01:   a_wdata = {2{mem_wr_data[15:0]}};
         default: a_wdata = mem_wr_data;
      endcase
   end

   // ---------------- port A read alignment ----------------
   logic       rd_zero_q, fault_q;
   logic [1:0] rd_off_q, rd_size_q;
   logic [31:0] a_shifted;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         rd_zero_q <= 1'b1;
         fault_q   <= 1'b0;
         rd_off_q  <= 2'b00;
         rd_size_q <= 2'b00;
      end else begin
         fault_q <= a_fault;
         if (mem_rst || a_fault) begin
            rd_zero_q <= 1'b1;
         end else if (mem_rd_en) begin
            rd_zero_q <= 1'b0;
            rd_off_q  <= mem_addr[1:0];
            rd_size_q <= mem_op[1:0];
         end
      end
   end

   always_comb begin
      a_shifted   = a_raw >> {rd_off_q, 3'b000};
      mem_rd_data = 32'h0;
      if (!rd_zero_q) begin
         case (rd_size_q)
            2'b00:   mem_rd_data = {24'h0, a_shifted[7:0]};
            2'b01:   mem_rd_data = {16'h0, a_shifted[15:0]};
            default: mem_rd_data = a_shifted;
         endcase
      end
   end

   assign mem_fault = fault_q;

   // ---------------- port B FSM ----------------
   dbg_state_t  b_state_q, b_state_d;
   logic [29:0] b_word_q;
   logic [31:0] b_wdata_q, dbg_rdata_q, b_raw, b_rd_val;
   logic        b_we_q, b_latch, b_go, b_collide, b_oor;

   assign b_oor     = {2'b00, b_word_q} >= 32'(DEPTH_WORDS);
   // A port A store to the word port B is about to access takes priority.
   assign b_collide = (a_be != 4'b0000) && (a_idx == b_word_q[AW-1:0]);
   assign b_rd_val  = b_oor ? 32'h0 : b_raw;

   always_comb begin
      b_state_d = b_state_q;
      b_latch   = 1'b0;
      b_go      = 1'b0;
      dbg_ack   = 1'b0;
      case (b_state_q)
         B_IDLE: begin
            if (dbg_req) begin
               b_latch   = 1'b1;
               b_state_d = B_ACCESS;
            end
         end
         B_ACCESS: begin
            if (!b_collide) begin
               b_go      = 1'b1;
               b_state_d = B_DONE;
            end
         end
         B_DONE: begin
            dbg_ack   = 1'b1;
            b_state_d = B_IDLE;
         end
         default: b_state_d = B_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         b_state_q   <= B_IDLE;
         dbg_rdata_q <= 32'h0;
      end else begin
         b_state_q <= b_state_d;
         if (dbg_ack && !b_we_q) dbg_rdata_q <= b_rd_val;
      end
   end

   always_ff @(posedge Clk) begin
      if (b_latch) begin
         b_word_q  <= dbg_addr[31:2];
         b_wdata_q <= dbg_wdata;
         b_we_q    <= dbg_we;
      end
   end

   // Read data goes straight out in the ack cycle, then the register holds it.
   assign dbg_rdata = (dbg_ack && !b_we_q) ? b_rd_val : dbg_rdata_q;

   logic unused_bits;
   assign unused_bits = ^{dbg_addr[1:0], mem_op[2]};

   dmem_bram #(
      .DEPTH     (DEPTH_WORDS),
      .AW        (AW),
      .INIT_FILE (INIT_FILE)
   ) u_bram (
      .clk_i     (Clk),
      .a_en_i    (mem_rd_en & ~a_fault),
      .a_be_i    (a_be),
      .a_addr_i  (a_idx),
      .a_wdata_i (a_wdata),
      .a_rdata_o (a_raw),
      .b_en_i    (b_go & ~b_we_q),
      .b_be_i    ((b_go & b_we_q & ~b_oor & Reset_n) ? 4'b1111 : 4'b0000),
      .b_addr_i  (b_word_q[AW-1:0]),
      .b_wdata_i (b_wdata_q),
      .b_rdata_o (b_raw)
   );

endmodule
